// File: rtl/rs_load_store_q.sv
// Purpose : age-ordered load/store reservation station with CDB operand capture and in-order store issue.
// Latency : an op dispatched ready (or bypassed from a CDB) can issue the cycle after dispatch; a wakeup at edge N issues after N.
// Backpres: disp_ready drops when all DEPTH slots are allocated; iss_* hold steady while iss_valid && !iss_ready.
//
// Ports:
//   clk, reset (sync, active-high), kill (flush all entries)
//   disp_*    : dispatch request (valid/ready), op fields; opN_rdy=0 means opN[TAG_W-1:0] is a tag
//   cdb_*     : NUM_CDB flattened broadcast buses (valid, tag, data); the lowest bus index wins on multiple hits
//   iss_*     : oldest eligible op to the LSU (valid/ready)
//   occupancy : slots allocated between head and tail
module rs_load_store_q #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 3,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter int FUNCT_W = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        kill,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic                        disp_is_store,
  input  logic [FUNCT_W-1:0]          disp_funct,
  input  logic [TAG_W-1:0]            disp_dest,
  input  logic                        disp_op1_rdy,
  input  logic [DATA_W-1:0]           disp_op1,
  input  logic                        disp_op2_rdy,
  input  logic [DATA_W-1:0]           disp_op2,
  input  logic [DATA_W-1:0]           disp_offset,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic                        iss_is_store,
  output logic [FUNCT_W-1:0]          iss_funct,
  output logic [TAG_W-1:0]            iss_dest,
  output logic [DATA_W-1:0]           iss_op1,
  output logic [DATA_W-1:0]           iss_op2,
  output logic [DATA_W-1:0]           iss_offset,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic               busy;
    logic               is_store;
    logic [FUNCT_W-1:0] funct;
    logic [TAG_W-1:0]   dest;
    logic               op1_rdy;
    logic [DATA_W-1:0]  op1;
    logic               op2_rdy;
    logic [DATA_W-1:0]  op2;
    logic [DATA_W-1:0]  offset;
  } entry_t;

  entry_t             ent [DEPTH];
  entry_t             disp_ent;
  logic [PTR_W-1:0]   head, tail, sel_idx, scan_idx, lock_idx;
  logic [CNT_W-1:0]   count;
  logic               sel_found, store_older, lock_vld;
  logic               disp_fire, iss_fire, head_busy_next, retire;
  logic [DATA_W:0]    byp1, byp2;

  // {hit, data} for a tag; buses scanned high to low so the lowest index overrides.
  function automatic logic [DATA_W:0] cdb_lookup(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == tag))
        r = {1'b1, cdb_data[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  assign disp_ready = (count < CNT_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_fire   = iss_valid && iss_ready;
  assign occupancy  = count;

  // Dispatch-cycle bypass: a tag broadcast in the same cycle is captured directly.
  assign byp1 = cdb_lookup(disp_op1[TAG_W-1:0]);
  assign byp2 = cdb_lookup(disp_op2[TAG_W-1:0]);

  always_comb begin
    disp_ent          = '0;
    disp_ent.busy     = 1'b1;
    disp_ent.is_store = disp_is_store;
    disp_ent.funct    = disp_funct;
    disp_ent.dest     = disp_dest;
    disp_ent.offset   = disp_offset;
    disp_ent.op1_rdy  = disp_op1_rdy || byp1[DATA_W];
    disp_ent.op1      = (!disp_op1_rdy && byp1[DATA_W]) ? byp1[DATA_W-1:0] : disp_op1;
    disp_ent.op2_rdy  = disp_op2_rdy || byp2[DATA_W];
    disp_ent.op2      = (!disp_op2_rdy && byp2[DATA_W]) ? byp2[DATA_W-1:0] : disp_op2;
  end

  // Oldest-first scan from head. Any busy store blocks every younger entry,
  // which keeps stores in order and stops loads from passing stores.
  // A stalled selection is locked so a newly woken older op cannot swap in.
  always_comb begin
    sel_found   = 1'b0;
    sel_idx     = '0;
    store_older = 1'b0;
    scan_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (!sel_found && !store_older && ent[scan_idx].busy &&
          ent[scan_idx].op1_rdy && ent[scan_idx].op2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
      if (ent[scan_idx].busy && ent[scan_idx].is_store)
        store_older = 1'b1;
    end
    if (lock_vld) begin
      sel_found = 1'b1;
      sel_idx   = lock_idx;
    end
  end

  assign iss_valid    = sel_found;
  assign iss_is_store = ent[sel_idx].is_store;
  assign iss_funct    = ent[sel_idx].funct;
  assign iss_dest     = ent[sel_idx].dest;
  assign iss_op1      = ent[sel_idx].op1;
  assign iss_op2      = ent[sel_idx].op2;
  assign iss_offset   = ent[sel_idx].offset;

  // Head retires when its slot is free after this edge's issue; one slot per cycle.
  assign head_busy_next = ent[head].busy && !(iss_fire && (sel_idx == head));
  assign retire         = (count != '0) && !head_busy_next;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    entry_t          ent_q;
    logic [DATA_W:0] wake1, wake2;

    assign wake1  = cdb_lookup(ent_q.op1[TAG_W-1:0]);
    assign wake2  = cdb_lookup(ent_q.op2[TAG_W-1:0]);
    assign ent[g] = ent_q;

    // Only busy needs a reset; payload is qualified by busy everywhere.
    always_ff @(posedge clk) begin
      if (reset || kill) begin
        ent_q.busy <= 1'b0;
      end else begin
        if (ent_q.busy && !ent_q.op1_rdy && wake1[DATA_W]) begin
          ent_q.op1     <= wake1[DATA_W-1:0];
          ent_q.op1_rdy <= 1'b1;
        end
        if (ent_q.busy && !ent_q.op2_rdy && wake2[DATA_W]) begin
          ent_q.op2     <= wake2[DATA_W-1:0];
          ent_q.op2_rdy <= 1'b1;
        end
        if (iss_fire && (sel_idx == PTR_W'(g)))
          ent_q.busy <= 1'b0;
        // The tail slot is never busy while disp_ready=1, so this cannot collide with the above.
        if (disp_fire && (tail == PTR_W'(g)))
          ent_q <= disp_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else begin
      if (disp_fire) tail <= tail + PTR_W'(1);
      if (retire)    head <= head + PTR_W'(1);
      if (disp_fire && !retire)      count <= count + CNT_W'(1);
      else if (!disp_fire && retire) count <= count - CNT_W'(1);
      lock_vld <= iss_valid && !iss_ready;
      lock_idx <= sel_idx;
    end
  end

endmodule

// File: tb/tb_rs_load_store_q.sv
// Purpose : scoreboard bench for rs_load_store_q: directed dispatch/CDB vectors, issue stream checked by a monitor.
// Latency : the monitor compares every accepted issue against the oldest queued expectation.
// Backpres: iss_ready is driven per scenario to exercise stalls.
module tb_rs_load_store_q;

  localparam int D  = 8;
  localparam int NC = 3;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int FW = 3;

  logic              clk = 1'b0;
  logic              reset, kill;
  logic              disp_valid, disp_ready, disp_is_store, disp_op1_rdy, disp_op2_rdy;
  logic [FW-1:0]     disp_funct;
  logic [TW-1:0]     disp_dest;
  logic [DW-1:0]     disp_op1, disp_op2, disp_offset;
  logic [NC-1:0]     cdb_valid;
  logic [NC*TW-1:0]  cdb_tag;
  logic [NC*DW-1:0]  cdb_data;
  logic              iss_valid, iss_ready, iss_is_store;
  logic [FW-1:0]     iss_funct;
  logic [TW-1:0]     iss_dest;
  logic [DW-1:0]     iss_op1, iss_op2, iss_offset;
  logic [$clog2(D):0] occupancy;

  always #5 clk = ~clk;

  rs_load_store_q #(.DEPTH(D), .NUM_CDB(NC), .TAG_W(TW), .DATA_W(DW), .FUNCT_W(FW)) dut (
    .clk(clk), .reset(reset), .kill(kill),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_store(disp_is_store),
    .disp_funct(disp_funct), .disp_dest(disp_dest), .disp_op1_rdy(disp_op1_rdy),
    .disp_op1(disp_op1), .disp_op2_rdy(disp_op2_rdy), .disp_op2(disp_op2),
    .disp_offset(disp_offset), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_is_store(iss_is_store),
    .iss_funct(iss_funct), .iss_dest(iss_dest), .iss_op1(iss_op1), .iss_op2(iss_op2),
    .iss_offset(iss_offset), .occupancy(occupancy)
  );

  typedef struct packed {
    logic          st;
    logic [FW-1:0] fn;
    logic [TW-1:0] dest;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] off;
  } exp_t;

  exp_t q[$];
  exp_t mon_got, mon_exp;
  int   checks = 0;
  int   errors = 0;

  // Monitor: every accepted issue must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && !kill && iss_valid && iss_ready) begin
      mon_got = {iss_is_store, iss_funct, iss_dest, iss_op1, iss_op2, iss_offset};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got dest=%0d op1=%h, required no issue", iss_dest, iss_op1);
      end else begin
        mon_exp = q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL issue_fields: got st=%0b fn=%0d dest=%0d op1=%h op2=%h off=%h, required st=%0b fn=%0d dest=%0d op1=%h op2=%h off=%h",
                   mon_got.st, mon_got.fn, mon_got.dest, mon_got.op1, mon_got.op2, mon_got.off,
                   mon_exp.st, mon_exp.fn, mon_exp.dest, mon_exp.op1, mon_exp.op2, mon_exp.off);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic set_cdb(input int b, input logic [TW-1:0] t, input logic [DW-1:0] d);
    cdb_valid[b]          = 1'b1;
    cdb_tag[b*TW +: TW]   = t;
    cdb_data[b*DW +: DW]  = d;
  endtask

  task automatic clr_cdb();
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
  endtask

  // Holds the request until disp_ready, then lets one edge accept it.
  task automatic disp(input logic st, input logic [FW-1:0] fn, input logic [TW-1:0] d,
                      input logic r1, input logic [DW-1:0] o1,
                      input logic r2, input logic [DW-1:0] o2, input logic [DW-1:0] off);
    int n;
    n = 0;
    disp_valid = 1'b1; disp_is_store = st; disp_funct = fn; disp_dest = d;
    disp_op1_rdy = r1; disp_op1 = o1; disp_op2_rdy = r2; disp_op2 = o2; disp_offset = off;
    while (!disp_ready && n < 50) begin
      tick();
      n++;
    end
    if (!disp_ready) begin
      checks++;
      errors++;
      $display("FAIL disp_timeout: got disp_ready=0 for 50 cycles, required 1");
    end
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending issues, required 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; kill = 1'b0; iss_ready = 1'b0;
    disp_valid = 1'b0; disp_is_store = 1'b0; disp_funct = '0; disp_dest = '0;
    disp_op1_rdy = 1'b0; disp_op1 = '0; disp_op2_rdy = 1'b0; disp_op2 = '0; disp_offset = '0;
    clr_cdb();
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);
    chk("reset_iss_valid",  64'(iss_valid),  64'd0);
    chk("reset_occupancy",  64'(occupancy),  64'd0);

    // Single ready load issues the cycle after dispatch and leaves the queue empty.
    iss_ready = 1'b1;
    q.push_back({1'b0, 3'd2, 6'd5, 32'h100, 32'h0, 32'h4});
    disp(1'b0, 3'd2, 6'd5, 1'b1, 32'h100, 1'b1, 32'h0, 32'h4);
    chk("single_iss_valid", 64'(iss_valid), 64'd1);
    chk("single_iss_dest",  64'(iss_dest),  64'd5);
    tick();
    chk("single_occ_after", 64'(occupancy), 64'd0);

    // Fill with waiting loads, refuse a 9th, then wake all from bus 2.
    for (int i = 0; i < D; i++) begin
      q.push_back({1'b0, 3'd1, 6'(10 + i), 32'hABCD, 32'h0, 32'(i)});
      disp(1'b0, 3'd1, 6'(10 + i), 1'b0, 32'd9, 1'b1, 32'h0, 32'(i));
    end
    chk("full_occupancy",  64'(occupancy),  64'd8);
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    disp_valid = 1'b1; disp_is_store = 1'b0; disp_dest = 6'd63;
    disp_op1_rdy = 1'b0; disp_op1 = 32'd9; disp_op2_rdy = 1'b1; disp_op2 = '0;
    tick();
    disp_valid = 1'b0;
    chk("full_ignored_occ", 64'(occupancy), 64'd8);
    chk("full_no_issue",    64'(iss_valid), 64'd0);
    set_cdb(2, 6'd9, 32'hABCD);
    tick();
    clr_cdb();
    drain("fill");
    tick();
    chk("fill_occ_empty", 64'(occupancy), 64'd0);

    // Load behind an unready store waits; lowest CDB bus wins on a double hit.
    disp(1'b1, 3'd0, 6'd50, 1'b1, 32'h200, 1'b0, 32'd3, 32'h8);
    disp(1'b0, 3'd4, 6'd51, 1'b1, 32'h300, 1'b1, 32'h0, 32'h0);
    tick();
    chk("store_blocks_load", 64'(iss_valid), 64'd0);
    q.push_back({1'b1, 3'd0, 6'd50, 32'h200, 32'h55, 32'h8});
    q.push_back({1'b0, 3'd4, 6'd51, 32'h300, 32'h0,  32'h0});
    set_cdb(0, 6'd3, 32'h55);
    set_cdb(1, 6'd3, 32'h66);
    tick();
    clr_cdb();
    chk("store_first_dest", 64'(iss_dest), 64'd50);
    drain("order");

    // Operand captured from a CDB in its dispatch cycle.
    q.push_back({1'b0, 3'd3, 6'd22, 32'h1234, 32'h0, 32'h10});
    set_cdb(0, 6'd7, 32'h1234);
    disp(1'b0, 3'd3, 6'd22, 1'b0, 32'd7, 1'b1, 32'h0, 32'h10);
    clr_cdb();
    chk("bypass_iss_valid", 64'(iss_valid), 64'd1);
    chk("bypass_iss_op1",   64'(iss_op1),   64'h1234);
    drain("bypass");

    // Stall: presented op stays put even when an older op wakes; kill flushes.
    iss_ready = 1'b0;
    disp(1'b0, 3'd0, 6'd30, 1'b0, 32'd11, 1'b1, 32'h0, 32'h0);
    disp(1'b0, 3'd0, 6'd31, 1'b1, 32'h300, 1'b1, 32'h0, 32'h0);
    chk("stall_c1_valid", 64'(iss_valid), 64'd1);
    chk("stall_c1_dest",  64'(iss_dest),  64'd31);
    set_cdb(1, 6'd11, 32'h77);
    tick();
    clr_cdb();
    chk("stall_c2_dest", 64'(iss_dest), 64'd31);
    chk("stall_c2_op1",  64'(iss_op1),  64'h300);
    tick();
    chk("stall_c3_dest", 64'(iss_dest),  64'd31);
    chk("stall_c3_occ",  64'(occupancy), 64'd2);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_iss_valid",  64'(iss_valid),  64'd0);
    chk("kill_occupancy",  64'(occupancy),  64'd0);
    chk("kill_disp_ready", 64'(disp_ready), 64'd1);

    // Stream through the ring several times with occasional stalls.
    for (int i = 0; i < 20; i++) begin
      iss_ready = ((i % 4) != 3);
      q.push_back({(i % 5) == 0, 3'(i % 8), 6'(40 + i), 32'h1000 + 32'(i), 32'(i), 32'(i * 4)});
      disp((i % 5) == 0, 3'(i % 8), 6'(40 + i), 1'b1, 32'h1000 + 32'(i), 1'b1, 32'(i), 32'(i * 4));
      chk("wrap_occ_bound", 64'(occupancy <= 4'd8), 64'd1);
    end
    iss_ready = 1'b1;
    drain("wrap");
    tick();
    chk("wrap_occ_empty", 64'(occupancy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_load_store_q.md
Name: rs_load_store_q

Overview:
- Parametrised load/store reservation station, successor to the fixed 4-entry LSU station. Sits between decode/dispatch and the LSU execute stage.
- Holds up to DEPTH memory ops in an age-ordered circular queue. Captures operands from NUM_CDB common data buses and issues the oldest eligible op through a valid/ready handshake.
- Enforces memory ordering: stores issue in program order, and no op issues ahead of an older un-issued store.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2
NUM_CDB, 3, number of CDB broadcast ports
TAG_W, 6, ROB/physical tag width
DATA_W, 32, operand/offset width
FUNCT_W, 3, access size/sign field width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
kill  in  1  flush all entries (branch mispredict)
disp_valid  in  1  dispatch request
disp_ready  out  1  entry available; registered-state function, not a function of disp_valid
disp_is_store  in  1  1=store, 0=load
disp_funct  in  FUNCT_W  size/sign code, passed through
disp_dest  in  TAG_W  destination tag
disp_op1_rdy  in  1  op1 holds data (1) or a tag in [TAG_W-1:0] (0)
disp_op1  in  DATA_W  base address data or tag
disp_op2_rdy  in  1  as op1, for store data
disp_op2  in  DATA_W  store data or tag
disp_offset  in  DATA_W  immediate offset
cdb_valid  in  NUM_CDB  per-bus broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  flattened tags, bus k at [k*TAG_W +: TAG_W]
cdb_data  in  NUM_CDB*DATA_W  flattened data
iss_valid  out  1  an op is presented to LSU
iss_ready  in  1  LSU accepts
iss_is_store, iss_funct, iss_dest, iss_op1, iss_op2, iss_offset  out  as dispatch  fields of issued entry
occupancy  out  $clog2(DEPTH)+1  allocated slots between head and tail

Behaviour:
- State: per-entry busy, is_store, funct, dest, op1/op2 with rdy bits, offset; head and tail pointers of width $clog2(DEPTH); count of width $clog2(DEPTH)+1.
- Reset or kill (kill takes priority over every other event that cycle):
  - all busy=0, head=tail=count=0.
  - Outputs next cycle: disp_ready=1, iss_valid=0, occupancy=0.
  - Other iss_* outputs are don't-care while iss_valid=0.
- disp_ready = (count < DEPTH).
- Allocation:
  - On disp_valid && disp_ready, write slot tail, set busy=1, tail++ (wraps modulo DEPTH), count++.
  - Dispatch with disp_ready=0 is ignored; the producer must hold the request.
- Dispatch-cycle bypass: if an operand is not ready and its tag matches a valid CDB in the same cycle, the entry stores the CDB data with rdy=1.
- Wakeup: for each busy entry and each operand with rdy=0, a match on a valid CDB bus latches the data and sets rdy=1 at the clock edge.
  - Tags compare on TAG_W bits only, qualified by cdb_valid.
  - If several buses match, the lowest bus index wins.
  - Non-busy entries ignore CDBs.
- Eligibility: entry is busy, op1 rdy, op2 rdy, and no older busy store exists between head and the entry.
  - Age order is position from head.
  - Loads may therefore pass loads only.
- Select and issue:
  - iss_valid=1 when any entry is eligible; iss_* carry the oldest eligible entry.
  - Issue is combinational from registered state, so an op woken at edge N can issue in the cycle after edge N.
  - iss_* are stable while iss_valid=1 && iss_ready=0, unless kill occurs.
  - On iss_valid && iss_ready the selected entry's busy is cleared at the edge.
- Head retirement: each edge, if count>0 and slot head is non-busy after this cycle's issue, then head++ and count--. At most one slot per cycle; holes behind head wait.
- Same cycle events:
  - Dispatch and retirement in the same cycle: count unchanged.
  - Dispatch while full with a simultaneous issue: not accepted (disp_ready is based on the registered count).
  - Issue of the head entry frees it and retires it in the same edge.

Test Plan:
- Reset, then dispatch load dest=5, op1 ready 0x100, op2 ready 0, offset 4 with iss_ready=1 -> next cycle iss_valid=1, iss_dest=5, iss_op1=0x100, iss_offset=4; the cycle after, occupancy=0.
- Fill DEPTH=8 loads with op1 tag=9 not ready -> disp_ready=0 after 8 accepts and a 9th request is ignored. Then cdb_valid[2]=1, tag 9, data 0xABCD -> all 8 wake and issue oldest-first over 8 cycles, iss_op1=0xABCD each.
- Store (op2 tag 3, not ready) then load (ready) -> the load is held (iss_valid=0). CDB tag 3 data 0x55 -> store issues with iss_op2=0x55, then the load next cycle.
- Dispatch an op with op1 tag 7 while CDB bus 0 broadcasts tag 7 data 0x1234 the same cycle -> the entry is ready immediately and issues next cycle with op1=0x1234.
- Hold iss_ready=0 for 3 cycles with an eligible entry -> iss_* constant and the entry is retained. Assert kill mid-stall -> next cycle iss_valid=0, occupancy=0, disp_ready=1.
- Pointer wrap: stream 20 dispatch/issue pairs through DEPTH=8 -> issue order matches dispatch order and occupancy never exceeds 8.
